xreg_wb_arb: RTL and testbench
==============================

XREG_WB_ARB -- requirements
Module: xreg_wb_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data width of one integer register.
REQ-002 SHALL have parameter DEPTH, default 4, the number of entries in the long-latency result FIFO; legal values are 2..16.
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port pipe_wb_valid, input, 1, a single-cycle pipeline writeback request; this port has no backpressure.
REQ-006 SHALL have ports pipe_wb_addr (input, 5) and pipe_wb_data (input, XLEN), the pipeline destination register and its data.
REQ-007 SHALL have ports lsu_valid (input, 1) and lsu_ready (output, 1), the long-latency result handshake.
REQ-008 SHALL have ports lsu_addr (input, 5) and lsu_data (input, XLEN), the long-latency destination register and its data.
REQ-009 SHALL have ports issue_valid (input, 1) and issue_addr (input, 5), which mark a long-latency destination as pending.
REQ-010 SHALL have ports rf_we (output, 1), rf_waddr (output, 5) and rf_wdata (output, XLEN), the registered register-file write port.
REQ-011 SHALL have port pending (output, 32), one bit per register; a set bit means a long-latency write is outstanding.
REQ-012 SHALL have port fifo_count (output, clog2(DEPTH+1)), the current FIFO occupancy.

Function
REQ-013 An LSU transfer SHALL occur exactly when lsu_valid and lsu_ready are both 1 in the same cycle.
REQ-014 lsu_ready SHALL be 1 iff fifo_count < DEPTH; it SHALL NOT depend on lsu_valid or on a same-cycle dequeue.
REQ-015 A transfer with lsu_addr != 0 SHALL enqueue {addr, data} at the clock edge.
REQ-016 A transfer with lsu_addr == 0 SHALL be accepted and discarded, without enqueue or write.
REQ-017 Pipeline priority: when pipe_wb_valid=1 and pipe_wb_addr!=0, at the next edge rf_we=1, rf_waddr=pipe_wb_addr and rf_wdata=pipe_wb_data.
REQ-018 FIFO drain: otherwise, if the FIFO is non-empty, the head SHALL be dequeued and presented on rf_* with rf_we=1 at the next edge.
REQ-019 Idle: otherwise rf_we=0 at the next edge, and rf_waddr/rf_wdata SHALL hold their previous values.
REQ-020 Pipeline requests with pipe_wb_addr==0 SHALL be treated as idle for that cycle, leaving the slot free for a FIFO drain.
REQ-021 Latency: a pipeline write SHALL appear on rf_* 1 cycle after request; an LSU write SHALL appear no earlier than 2 cycles after transfer (no FIFO bypass).
REQ-022 FIFO ordering SHALL be strict FIFO, with wrap-around pointers mod DEPTH.
REQ-023 A simultaneous enqueue and dequeue SHALL leave fifo_count unchanged.
REQ-024 issue_valid with issue_addr!=0 SHALL set pending[issue_addr] at the edge.
REQ-025 A FIFO-sourced commit to register r SHALL clear pending[r] at the same edge that rf_we is asserted for it.
REQ-026 A set and a clear of the same bit in one cycle SHALL leave the bit set.
REQ-027 pending[0] SHALL be constant 0.
REQ-028 Pipeline-sourced writes SHALL NOT affect pending.
REQ-029 The issue logic guarantees that no pipeline write targets a pending register; the block SHALL NOT reorder writes to resolve such a conflict.
REQ-030 The block SHALL NOT drop a pending FIFO entry under any pipeline traffic pattern.

Reset
REQ-031 On rst_n=0, asynchronously: rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, fifo_count=0 (so lsu_ready=1), and both FIFO pointers=0.
REQ-032 Reset mid-operation SHALL discard all queued FIFO entries and pending bits.
REQ-033 The first write after reset release SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-034 Pipeline write: pipe_wb_valid=1, addr=5, data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; pending unchanged.
REQ-035 Issue then LSU result: issue addr=7, then LSU transfer addr=7, data=0x1234 with pipeline idle -> pending[7]=1 from the issue edge; rf_we for r7 2 cycles after the transfer; pending[7]=0 on that same edge.
REQ-036 Full FIFO with pipeline busy: DEPTH=4, pipe_wb_valid=1 (addr!=0) every cycle, 5 LSU requests -> 4 accepted, lsu_ready=0 with fifo_count=4; after the pipeline idles, 4 writes emerge in order on consecutive cycles, then lsu_ready=1.
REQ-037 Address-zero cases: LSU addr=0 -> accepted, fifo_count unchanged, no rf_we; pipeline addr=0 with FIFO non-empty -> FIFO head written in that slot.
REQ-038 Set/clear collision: issue addr=9 in the same cycle r9's FIFO entry commits -> pending[9] remains 1.
REQ-039 Reset mid-stream: 3 entries queued and pending=0x0000_0380, assert rst_n=0 -> rf_we=0, fifo_count=0, pending=0 immediately; no writes after release until new requests arrive.

Source files
------------

// File: rtl/xreg_wb_arb.sv
// Register-file writeback arbiter: the pipeline has priority and a FIFO
// buffers long-latency results. The block also tracks a pending-write scoreboard.
module xreg_wb_arb #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_wb_valid,
  input  logic [4:0]      pipe_wb_addr,
  input  logic [XLEN-1:0] pipe_wb_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_addr,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_addr,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     pending,
  output logic [CW-1:0]   fifo_count
);

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } entry_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ?
      '0 : p + PW'(1);
  endfunction

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          pipeWr;
  logic          enq;
  logic          deq;
  logic [31:0]   setMask;
  logic [31:0]   clrMask;
  logic [31:0]   pendingNext;

  assign lsu_ready = fifo_count < FULL;
  assign head      = mem[rdPtr];
  assign pipeWr    = pipe_wb_valid &&
                     (pipe_wb_addr != 5'd0);
  // Address-zero results are accepted but never stored.
  assign enq       = lsu_valid && lsu_ready &&
                     (lsu_addr != 5'd0);
  assign deq       = !pipeWr &&
                     (fifo_count != '0);

  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (issue_valid && issue_addr != 5'd0)
      setMask[issue_addr] = 1'b1;
    if (deq)
      clrMask[head.addr] = 1'b1;
    // Set wins over clear; bit 0 never set.
    pendingNext = ((pending & ~clrMask) | setMask)
                & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (enq)
      mem[wrPtr] <= '{addr: lsu_addr, data: lsu_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
    end else begin
      if (enq)
        wrPtr <= bump(wrPtr);
      if (deq)
        rdPtr <= bump(rdPtr);
      unique case ({enq, deq})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pendingNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      unique case (1'b1)
        pipeWr: begin
          rf_we    <= 1'b1;
          rf_waddr <= pipe_wb_addr;
          rf_wdata <= pipe_wb_data;
        end
        deq: begin
          rf_we    <= 1'b1;
          rf_waddr <= head.addr;
          rf_wdata <= head.data;
        end
        default: begin
          rf_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xreg_wb_arb.sv
// Directed bench for xreg_wb_arb: a vector table followed by
// hand-written full-FIFO and mid-stream reset sequences.
module tb_xreg_wb_arb;

  logic        clk;
  logic        rst_n;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_addr;
  logic [31:0] pipe_wb_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  int nCmp;
  int nBad;

  xreg_wb_arb #(.XLEN(32), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_wb_addr  (pipe_wb_addr),
    .pipe_wb_data  (pipe_wb_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_addr      (lsu_addr),
    .lsu_data      (lsu_data),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .pending       (pending),
    .fifo_count    (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ia;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pend;
    logic [2:0]  cnt;
    logic        rdy;
  } vec_t;

  vec_t vecs [17];

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input logic pv, input logic [4:0] pa,
    input logic [31:0] pd,
    input logic lv, input logic [4:0] la,
    input logic [31:0] ld,
    input logic iv, input logic [4:0] ia
  );
    pipe_wb_valid = pv;
    pipe_wb_addr  = pa;
    pipe_wb_data  = pd;
    lsu_valid     = lv;
    lsu_addr      = la;
    lsu_data      = ld;
    issue_valid   = iv;
    issue_addr    = ia;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(
    input string tag,
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic [31:0] pend,
    input logic [2:0] cnt, input logic rdy
  );
    check({tag, ".rf_we"}, 32'(rf_we), 32'(we));
    check({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(wa));
    check({tag, ".rf_wdata"}, rf_wdata, wd);
    check({tag, ".pending"}, pending, pend);
    check({tag, ".fifo_count"},
          32'(fifo_count), 32'(cnt));
    check({tag, ".lsu_ready"},
          32'(lsu_ready), 32'(rdy));
  endtask

  initial begin
    nCmp = 0;
    nBad = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // pipe | lsu | issue | expected after edge
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,
                 1, 5, 32'hDEADBEEF, 0, 0, 1};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                 0, 5, 32'hDEADBEEF, 0, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 1, 7,
                 0, 5, 32'hDEADBEEF, 32'h80, 0, 1};
    vecs[3]  = '{0, 0, 0, 1, 7, 32'h1234, 0, 0,
                 0, 5, 32'hDEADBEEF, 32'h80, 1, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                 1, 7, 32'h1234, 0, 0, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                 0, 7, 32'h1234, 0, 0, 1};
    vecs[6]  = '{0, 0, 0, 1, 0, 32'h55, 0, 0,
                 0, 7, 32'h1234, 0, 0, 1};
    vecs[7]  = '{1, 0, 32'h99, 0, 0, 0, 1, 3,
                 0, 7, 32'h1234, 32'h8, 0, 1};
    vecs[8]  = '{1, 4, 32'h44, 1, 3, 32'h33, 0, 0,
                 1, 4, 32'h44, 32'h8, 1, 1};
    vecs[9]  = '{1, 0, 32'hAA, 0, 0, 0, 0, 0,
                 1, 3, 32'h33, 0, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 9,
                 0, 3, 32'h33, 32'h200, 0, 1};
    vecs[11] = '{0, 0, 0, 1, 9, 32'h99, 0, 0,
                 0, 3, 32'h33, 32'h200, 1, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 1, 9,
                 1, 9, 32'h99, 32'h200, 0, 1};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0,
                 0, 9, 32'h99, 32'h200, 0, 1};
    vecs[14] = '{0, 0, 0, 1, 10, 32'hA, 0, 0,
                 0, 9, 32'h99, 32'h200, 1, 1};
    vecs[15] = '{0, 0, 0, 1, 11, 32'hB, 0, 0,
                 1, 10, 32'hA, 32'h200, 1, 1};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0,
                 1, 11, 32'hB, 32'h200, 0, 1};

    #12;
    checkAll("reset", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].pv, vecs[i].pa, vecs[i].pd,
            vecs[i].lv, vecs[i].la, vecs[i].ld,
            vecs[i].iv, vecs[i].ia);
      tick();
      checkAll($sformatf("vec%0d", i),
               vecs[i].we, vecs[i].wa, vecs[i].wd,
               vecs[i].pend, vecs[i].cnt, vecs[i].rdy);
    end

    // Full FIFO under continuous pipeline traffic.
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 32'(k), 1, 5'(12 + k),
            32'h100 + 32'(k), 0, 0);
      tick();
      checkAll($sformatf("full%0d", k), 1, 1,
               32'(k), 32'h200,
               (k < 4) ? 3'(k + 1) : 3'd4,
               k < 3);
    end
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checkAll($sformatf("drain%0d", j), 1,
               5'(12 + j), 32'h100 + 32'(j),
               32'h200, 3'(3 - j), 1);
    end
    tick();
    checkAll("drainIdle", 0, 15, 32'h103,
             32'h200, 0, 1);

    // Three queued entries, then reset mid-cycle.
    for (int k = 0; k < 3; k++) begin
      drive(1, 2, 32'hC0 + 32'(k), 1, 5'(7 + k),
            32'(k), 1, 5'(7 + k));
      tick();
    end
    checkAll("preRst", 1, 2, 32'hC2,
             32'h380, 3, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("midRst", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkAll($sformatf("postRst%0d", k),
               0, 0, 0, 0, 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
